// File: rtl/fp_op_scheduler.sv
// rtl/fp_op_scheduler.sv - sequences operand pairs from instruction memory through the FPU
// FP_SCHED_TIMEOUT_EN adds a WAIT_RES watchdog that aborts the batch and sets timeout_err.
module fp_op_scheduler #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef FP_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_ops,
  input  logic [1:0]        op_sel,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_a,
  input  logic [31:0]       mem_b,
  output logic              fpu_valid,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic [1:0]        fpu_op,
  input  logic              fpu_ready,
  input  logic              fpu_done,
  input  logic [31:0]       fpu_result,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    WAIT_RES,
    NEXT,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   start_count;

  assign idx_inc     = {1'b0, idx} + (ADDR_W+1)'(1);
  assign start_count = (num_ops > DEPTH_W) ? DEPTH_W : num_ops;

`ifdef FP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      fpu_valid <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FP_SCHED_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      mem_rd    <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count  <= start_count;
            fpu_op <= op_sel;
            idx    <= '0;
            busy   <= 1'b1;
`ifdef FP_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (start_count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
            end
          end
        end
        FETCH: state <= WAIT_MEM;
        WAIT_MEM: begin
          fpu_a     <= mem_a;
          fpu_b     <= mem_b;
          fpu_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          // fpu_done seen on the handshake cycle belongs to nothing we issued
          if (fpu_ready) begin
            fpu_valid <= 1'b0;
            state     <= WAIT_RES;
`ifdef FP_SCHED_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        WAIT_RES: begin
          if (fpu_done) begin
            res_data  <= fpu_result;
            res_idx   <= idx;
            res_valid <= 1'b1;
            state     <= NEXT;
          end
`ifdef FP_SCHED_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        NEXT: begin
          // idx stays at the last operand rather than wrapping past DEPTH-1
          if (idx_inc == count) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            idx      <= idx_inc[ADDR_W-1:0];
            mem_addr <= idx_inc[ADDR_W-1:0];
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// tb/tb_fp_op_scheduler.sv - self-checking bench for fp_op_scheduler
`timescale 1ns/1ps
module tb_fp_op_scheduler;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   num_ops;
  logic [1:0]        op_sel;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_a;
  logic [31:0]       mem_b;
  logic              fpu_valid;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic [1:0]        fpu_op;
  logic              fpu_ready;
  logic              fpu_done;
  logic [31:0]       fpu_result;
  logic              res_valid;
  logic [31:0]       res_data;
  logic [ADDR_W-1:0] res_idx;
  logic              busy;
  logic              done;
  logic              timeout_err;

  always #5 clk = ~clk;

  fp_op_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .op_sel(op_sel),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_a(mem_a), .mem_b(mem_b),
    .fpu_valid(fpu_valid), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_ready(fpu_ready), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_av [DEPTH];
  logic [31:0] mem_bv [DEPTH];

  int rw_cfg = 0;
  int dl_cfg = 1;
  bit spur_cfg = 1'b0;

  int          rd_q[$];
  int          res_idx_q[$];
  logic [31:0] res_data_q[$];
  logic [31:0] iss_a_q[$];
  logic [31:0] iss_b_q[$];
  logic [1:0]  iss_op_q[$];
  int unstable = 0;
  int done_seen = 0;
  int fv_seen = 0;
  int mem_pending = -1;
  int vcnt = 0;
  int dcnt = 0;
  bit prev_wait = 1'b0;
  logic [31:0] prev_a, prev_b, pa, pb;
  logic [1:0]  prev_op, pop;

  // stand-in arithmetic: the scheduler only moves words, so any distinct function will do
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // monitor, instruction memory and FPU responder share one block so their order is fixed
  always @(negedge clk) begin
    if (mem_rd === 1'b1) rd_q.push_back(int'(mem_addr));
    if (res_valid === 1'b1) begin
      res_idx_q.push_back(int'(res_idx));
      res_data_q.push_back(res_data);
    end
    if (done === 1'b1) done_seen++;
    if (fpu_valid === 1'b1) fv_seen++;
    if (fpu_valid === 1'b1 && prev_wait && (fpu_a !== prev_a || fpu_b !== prev_b || fpu_op !== prev_op))
      unstable++;

    if (mem_pending >= 0) begin
      mem_a = mem_av[mem_pending];
      mem_b = mem_bv[mem_pending];
    end else begin
      mem_a = $urandom;
      mem_b = $urandom;
    end
    mem_pending = (mem_rd === 1'b1) ? int'(mem_addr) : -1;

    fpu_done   = 1'b0;
    fpu_result = $urandom;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        fpu_done   = 1'b1;
        fpu_result = fpu_fn(pa, pb, pop);
      end
    end
    prev_wait = 1'b0;
    if (rst_n !== 1'b1) begin
      fpu_ready = 1'b0;
      vcnt = 0;
    end else if (fpu_valid === 1'b1) begin
      if (vcnt >= rw_cfg) begin
        fpu_ready = 1'b1;
        vcnt = 0;
        iss_a_q.push_back(fpu_a);
        iss_b_q.push_back(fpu_b);
        iss_op_q.push_back(fpu_op);
        pa = fpu_a; pb = fpu_b; pop = fpu_op;
        dcnt = dl_cfg;
        if (spur_cfg) begin
          fpu_done   = 1'b1;
          fpu_result = $urandom;
        end
      end else begin
        fpu_ready = 1'b0;
        vcnt++;
        prev_wait = 1'b1;
      end
    end else begin
      fpu_ready = 1'($urandom);
    end
    prev_a = fpu_a; prev_b = fpu_b; prev_op = fpu_op;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rd_q.delete(); res_idx_q.delete(); res_data_q.delete();
    iss_a_q.delete(); iss_b_q.delete(); iss_op_q.delete();
    unstable = 0; done_seen = 0; fv_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_rd"}, 32'(mem_rd), 0);
    check({tag, " mem_addr"}, 32'(mem_addr), 0);
    check({tag, " fpu_valid"}, 32'(fpu_valid), 0);
    check({tag, " fpu_a"}, fpu_a, 0);
    check({tag, " fpu_b"}, fpu_b, 0);
    check({tag, " fpu_op"}, 32'(fpu_op), 0);
    check({tag, " res_valid"}, 32'(res_valid), 0);
    check({tag, " res_data"}, res_data, 0);
    check({tag, " res_idx"}, 32'(res_idx), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic run_batch(input string tag, input int n, input logic [1:0] op, input int rw,
                           input int dl, input bit spur, input int exp_ops, input int exp_lat);
    int m, t0, lat;
    bit got;
    m = (n < DEPTH) ? n : DEPTH;
    rw_cfg = rw; dl_cfg = dl; spur_cfg = spur;
    clear_obs();
    step();
    start = 1'b1; num_ops = (ADDR_W+1)'(n); op_sel = op;
    step();
    t0 = cyc;
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 1);
    check({tag, " mem_rd_after_start"}, 32'(mem_rd), 32'(m > 0));
    got = 1'b0; lat = -1;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0 + 1;
      end else begin
        if (spur && k >= 1 && k <= 3) begin
          start = 1'b1; num_ops = 1; op_sel = ~op;
        end else begin
          start = 1'b0;
        end
        step();
      end
    end
    start = 1'b0;
    check({tag, " done_latency"}, 32'(lat), 32'(exp_lat));
    step();
    check({tag, " busy_idle"}, 32'(busy), 0);
    repeat (3) step();
    check({tag, " done_pulses"}, 32'(done_seen), 1);
    check({tag, " res_count"}, 32'(res_idx_q.size()), 32'(exp_ops));
    check({tag, " rd_count"}, 32'(rd_q.size()), 32'(m));
    check({tag, " valid_cycles"}, 32'(fv_seen), 32'(m * (rw + 1)));
    check({tag, " operand_stability"}, 32'(unstable), 0);
    for (int i = 0; i < m; i++) begin
      if (i < rd_q.size()) check($sformatf("%s mem_addr[%0d]", tag, i), 32'(rd_q[i]), 32'(i));
      if (i < iss_a_q.size()) begin
        check($sformatf("%s fpu_a[%0d]", tag, i), iss_a_q[i], mem_av[i]);
        check($sformatf("%s fpu_b[%0d]", tag, i), iss_b_q[i], mem_bv[i]);
        check($sformatf("%s fpu_op[%0d]", tag, i), 32'(iss_op_q[i]), 32'(op));
      end
      if (i < res_idx_q.size()) begin
        check($sformatf("%s res_idx[%0d]", tag, i), 32'(res_idx_q[i]), 32'(i));
        check($sformatf("%s res_data[%0d]", tag, i), res_data_q[i], fpu_fn(mem_av[i], mem_bv[i], op));
      end
    end
  endtask

  typedef struct {
    int n; int op; int rw; int dl; bit spur;
    int exp_ops; int exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, lat, m, n, rw, dl;
    logic [1:0] op;
    bit got;

    vecs[0] = '{n: 3,  op: 0, rw: 0, dl: 1, spur: 0, exp_ops: 3,  exp_lat: 16};
    vecs[1] = '{n: 0,  op: 1, rw: 0, dl: 1, spur: 0, exp_ops: 0,  exp_lat: 1};
    vecs[2] = '{n: 20, op: 2, rw: 0, dl: 1, spur: 0, exp_ops: 16, exp_lat: 81};
    vecs[3] = '{n: 1,  op: 3, rw: 7, dl: 1, spur: 1, exp_ops: 1,  exp_lat: 13};
    vecs[4] = '{n: 16, op: 1, rw: 0, dl: 1, spur: 0, exp_ops: 16, exp_lat: 81};
    vecs[5] = '{n: 5,  op: 2, rw: 2, dl: 3, spur: 0, exp_ops: 5,  exp_lat: 46};
    vecs[6] = '{n: 17, op: 0, rw: 1, dl: 2, spur: 0, exp_ops: 16, exp_lat: 113};

    for (int i = 0; i < DEPTH; i++) begin
      mem_av[i] = $urandom;
      mem_bv[i] = $urandom;
    end
    mem_av[0] = 32'h3F80_0000; mem_av[1] = 32'h4000_0000; mem_av[2] = 32'h4040_0000;
    mem_bv[0] = 32'h3F80_0000; mem_bv[1] = 32'h3F80_0000; mem_bv[2] = 32'h3F80_0000;

    rst_n = 1'b0; start = 1'b0; num_ops = '0; op_sel = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++)
      run_batch($sformatf("vec%0d", v), vecs[v].n, 2'(vecs[v].op), vecs[v].rw, vecs[v].dl,
                vecs[v].spur, vecs[v].exp_ops, vecs[v].exp_lat);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_av[i] = $urandom;
        mem_bv[i] = $urandom;
      end
      n  = $urandom_range(0, 20);
      op = 2'($urandom_range(0, 3));
      rw = $urandom_range(0, 3);
      dl = $urandom_range(1, 3);
      m  = (n < DEPTH) ? n : DEPTH;
      run_batch($sformatf("rnd%0d", r), n, op, rw, dl, 1'b0, m,
                (m == 0) ? 1 : m * (4 + rw + dl) + 1);
    end

    // reset while op 1 waits for its result; its fpu_done lands while reset is held
    rw_cfg = 0; dl_cfg = 3; spur_cfg = 1'b0;
    clear_obs();
    step();
    start = 1'b1; num_ops = 3; op_sel = 2'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 200 && iss_a_q.size() < 2; k++) step();
    check("rst_mid issued_two", 32'(iss_a_q.size()), 2);
    step();
    rst_n = 1'b0;
    step();
    check_reset_outputs("rst_mid");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_mid res_count", 32'(res_idx_q.size()), 1);
    check("rst_mid rd_count", 32'(rd_q.size()), 2);
    check("rst_mid done_pulses", 32'(done_seen), 0);
    check("rst_mid busy", 32'(busy), 0);
    dl_cfg = 1;

`ifdef FP_SCHED_TIMEOUT_EN
    rw_cfg = 0; dl_cfg = 0;
    clear_obs();
    step();
    start = 1'b1; num_ops = 2; op_sel = 2'd1;
    step();
    t0 = cyc;
    start = 1'b0;
    got = 1'b0; lat = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0 + 1;
      end else begin
        step();
      end
    end
    check("tmo done_latency", 32'(lat), 68);
    check("tmo timeout_err", 32'(timeout_err), 1);
    check("tmo res_count", 32'(res_idx_q.size()), 0);
    check("tmo rd_count", 32'(rd_q.size()), 1);
    step();
    check("tmo sticky", 32'(timeout_err), 1);
    check("tmo busy_idle", 32'(busy), 0);
    start = 1'b1; num_ops = 0;
    step();
    start = 1'b0;
    check("tmo cleared_on_start", 32'(timeout_err), 0);
    step();
    dl_cfg = 1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_op_scheduler.md
# fp_op_scheduler

Sequences batches of operand pairs from the operand instruction memory into the 32-bit floating-point arithmetic unit, one operation at a time. It fetches each A/B pair, issues it to the FPU with a valid/ready handshake, and waits for the FPU's completion strobe. It then forwards each result with its index to the result sink. It sits between the instruction memory and the FPU core and is the only master of both during a batch.

## Interface
- DEPTH, 16: number of operand entries in instruction memory.
- ADDR_W, 4: memory address width; DEPTH ≤ 2^ADDR_W.
- TIMEOUT, 64: maximum cycles spent in WAIT_RES before abort (only with FP_SCHED_TIMEOUT_EN).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  batch start request; sampled in IDLE only.
- num_ops  in  ADDR_W+1  operations in batch; captured on accepted start.
- op_sel  in  2  00 add, 01 sub, 10 mul, 11 div; captured on accepted start.
- mem_rd  out  1  one-cycle read strobe to instruction memory.
- mem_addr  out  ADDR_W  read address.
- mem_a, mem_b  in  32  operand pair, valid exactly one cycle after mem_rd.
- fpu_valid  out  1  operands presented to FPU.
- fpu_a, fpu_b  out  32  operands.
- fpu_op  out  2  latched op_sel.
- fpu_ready  in  1  FPU accepts when fpu_valid & fpu_ready.
- fpu_done  in  1  one-cycle completion strobe.
- fpu_result  in  32  result, valid with fpu_done.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  32  result word.
- res_idx  out  ADDR_W  operand index of result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle batch-complete pulse.
- timeout_err  out  1  sticky FPU timeout flag.

## Operation
- FSM states: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_RES, NEXT, FIN.
- IDLE: on start, latch the count as min(num_ops, DEPTH) and latch op_sel. Clear idx. Clear timeout_err. Go to FETCH; if the latched count is 0, go straight to FIN.
- FETCH: mem_rd=1 and mem_addr=idx for one cycle, then WAIT_MEM.
- WAIT_MEM: capture mem_a/mem_b into the operand registers, then ISSUE.
- ISSUE: fpu_valid=1 with stable fpu_a/fpu_b/fpu_op until fpu_ready. On handshake, go to WAIT_RES.
- WAIT_RES: ignore fpu_done during the ISSUE handshake cycle. On fpu_done, capture fpu_result and go to NEXT.
- NEXT: res_valid=1, res_data=captured result, res_idx=idx. Increment idx. If idx+1 == count, go to FIN; else go to FETCH.
- FIN: done=1 for one cycle, then IDLE.
- start while busy: ignored, never queued.
- idx never wraps: count ≤ DEPTH, so the final idx is DEPTH-1.
- rst_n low in any state: next cycle is IDLE with all outputs at reset values; an in-flight FPU result is discarded.

## Timing
- Reset values: mem_rd=0, mem_addr=0, fpu_valid=0, fpu_a=fpu_b=0, fpu_op=0, res_valid=0, res_data=0, res_idx=0, busy=0, done=0, timeout_err=0.
- All outputs are registered.
- start accepted at edge T: mem_rd is high in cycle T+1.
- Per operation: FETCH 1 + WAIT_MEM 1 + ISSUE ≥1 + WAIT_RES ≥1 + NEXT 1, so the minimum is 5 cycles with fpu_ready already high and fpu_done one cycle after the handshake.
- Batch of N with immediate FPU: done occurs 5N+1 cycles after start is accepted.
- num_ops=0: done occurs in cycle T+1, busy is high for exactly that cycle, no mem_rd is issued.

## Configuration
- FP_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT_RES.
  - If fpu_done has not arrived after TIMEOUT cycles, set timeout_err (sticky until the next accepted start).
  - Skip res_valid and go directly to FIN, which pulses done. The remaining ops are abandoned.
- FP_SCHED_TIMEOUT_EN undefined:
  - No counter; WAIT_RES waits indefinitely.
  - timeout_err is tied to 0.

## Test plan
- Reset then start, num_ops=3, op_sel=00, memory A_i=i+1.0 / B_i=1.0, FPU ready and done immediate → mem_addr 0,1,2 in order; res_idx 0,1,2; done exactly 16 cycles after start.
- num_ops=0 → done the cycle after start; no mem_rd, fpu_valid or res_valid.
- num_ops=20 with DEPTH=16 → exactly 16 res_valid pulses, last res_idx=15.
- fpu_ready held low 7 cycles → fpu_valid, fpu_a, fpu_b stable throughout; issue on the 8th cycle; start pulses mid-batch ignored.
- rst_n low during WAIT_RES of op 1, with fpu_done arriving during reset → next cycle IDLE, all outputs at reset values, no res_valid.
- With FP_SCHED_TIMEOUT_EN and TIMEOUT=64, fpu_done never asserted → timeout_err=1 and done pulse after 64 WAIT_RES cycles; timeout_err clears on the next start.
